// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register dump reader.
// FSM encoding and word/address geometry.
package reg_dump_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int REG_ADDR_W     = 5;
  localparam int BYTE_IDX_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_dump_ser.sv
// 32-to-8 byte serializer with valid/ready hold.
// Loads a word, emits four bytes, flags the 4th.
module reg_dump_ser
  import reg_dump_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        reg_clock,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic        last_word_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_last_o,
  output logic        word_done_o
);

  logic [31:0]           sh_q, sh_d;
  logic [BYTE_IDX_W-1:0] idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic                  xfer;
  logic                  fourth;

  localparam logic [BYTE_IDX_W-1:0] LAST_IDX =
    BYTE_IDX_W'(BYTES_PER_WORD - 1);

  assign xfer   = vld_q & tx_ready_i;
  assign fourth = (idx_q == LAST_IDX);

  assign tx_valid_o  = vld_q;
  assign tx_data_o   = MSB_FIRST ? sh_q[31:24]
                                 : sh_q[7:0];
  assign tx_last_o   = vld_q & fourth & last_word_i;
  assign word_done_o = xfer & fourth;

  // Next word on load, otherwise shift on each accepted byte.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    vld_d = vld_q;
    if (load_i) begin
      sh_d  = word_i;
      idx_d = '0;
      vld_d = 1'b1;
    end else if (xfer) begin
      sh_d  = MSB_FIRST ? {sh_q[23:0], 8'h00}
                        : {8'h00, sh_q[31:8]};
      idx_d = idx_q + 1'b1;
      if (fourth) begin
        vld_d = 1'b0;
      end
    end
  end

  // Serializer state; held while the sink stalls.
  always_ff @(posedge reg_clock or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
      vld_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
      vld_q <= vld_d;
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Register-file dump reader: fetches a range of
// registers and streams them out as bytes.
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  reg_clock,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] first_addr,
  input  logic [REG_ADDR_W-1:0] last_addr,
  output logic                  rd_ena,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [31:0]           rd_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_last,
  output logic                  busy,
  output logic                  done
);

  state_t                state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] first_q, first_d;
  logic [REG_ADDR_W-1:0] last_q, last_d;
  logic [REG_ADDR_W-1:0] ofs;
  logic [REG_ADDR_W-1:0] span;
  logic                  last_word;
  logic                  word_done;

  // Offset of the current word vs. the dump span,
  // both modulo 32 so a wrapped range works.
  assign ofs       = cnt_q - first_q;
  assign span      = last_q - first_q;
  assign last_word = (ofs == span);

  assign rd_ena  = (state_q == FETCH);
  assign rd_addr = cnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  reg_dump_ser #(
    .MSB_FIRST (MSB_FIRST)
  ) u_ser (
    .reg_clock   (reg_clock),
    .rst         (rst),
    .load_i      (state_q == FETCH),
    .word_i      (rd_data),
    .last_word_i (last_word),
    .tx_ready_i  (tx_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_last_o   (tx_last),
    .word_done_o (word_done)
  );

  // Dump sequencing and address counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          first_d = first_addr;
          last_d  = last_addr;
          cnt_d   = first_addr;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = SEND;
      end
      SEND: begin
        if (word_done) begin
          if (last_word) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and address registers, async reset.
  always_ff @(posedge reg_clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader.
// Two instances (MSB/LSB first) share all inputs.
module tb_reg_dump_reader;

  logic        reg_clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_addr = '0;
  logic [4:0]  last_addr = '0;
  logic        tx_ready = 1'b1;
  logic [31:0] regs [32];

  logic        rd_ena_m, rd_ena_l;
  logic [4:0]  rd_addr_m, rd_addr_l;
  logic [31:0] rd_data_m, rd_data_l;
  logic        tx_valid_m, tx_valid_l;
  logic [7:0]  tx_data_m, tx_data_l;
  logic        tx_last_m, tx_last_l;
  logic        busy_m, busy_l;
  logic        done_m, done_l;

  assign rd_data_m = regs[rd_addr_m];
  assign rd_data_l = regs[rd_addr_l];

  always #5 reg_clock = ~reg_clock;

  reg_dump_reader #(.MSB_FIRST(1'b1)) u_msb (
    .reg_clock  (reg_clock),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_ena     (rd_ena_m),
    .rd_addr    (rd_addr_m),
    .rd_data    (rd_data_m),
    .tx_valid   (tx_valid_m),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data_m),
    .tx_last    (tx_last_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  reg_dump_reader #(.MSB_FIRST(1'b0)) u_lsb (
    .reg_clock  (reg_clock),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_ena     (rd_ena_l),
    .rd_addr    (rd_addr_l),
    .rd_data    (rd_data_l),
    .tx_valid   (tx_valid_l),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data_l),
    .tx_last    (tx_last_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(
    logic [31:0] w, int i, bit msb);
    int s;
    s = msb ? 8 * (3 - i) : 8 * i;
    return 8'(w >> s);
  endfunction

  // Transaction-level model: pending words and addresses.
  logic [31:0] words [$];
  logic [4:0]  addrs [$];
  int          bidx = 0;
  bit          active = 0;
  bit          fetch_now = 0;
  bit          done_now = 0;
  bit          ev, fn, dn;
  int          nwords;

  logic [7:0]  log_m [$];
  logic [7:0]  log_l [$];
  logic [4:0]  log_a [$];
  int          done_cnt = 0;

  always @(negedge reg_clock) begin
    if (rst) begin
      active = 0;
      fetch_now = 0;
      done_now = 0;
      bidx = 0;
      words.delete();
      addrs.delete();
      chk("rst_out_m", {rd_ena_m, rd_addr_m, tx_valid_m,
          tx_data_m, tx_last_m, busy_m, done_m}, 0);
      chk("rst_out_l", {rd_ena_l, rd_addr_l, tx_valid_l,
          tx_data_l, tx_last_l, busy_l, done_l}, 0);
    end else begin
      ev = active && !fetch_now && !done_now;
      chk("busy_m", busy_m, active);
      chk("busy_l", busy_l, active);
      chk("rd_ena_m", rd_ena_m, fetch_now);
      chk("rd_ena_l", rd_ena_l, fetch_now);
      chk("done_m", done_m, done_now);
      chk("done_l", done_l, done_now);
      chk("tx_valid_m", tx_valid_m, ev);
      chk("tx_valid_l", tx_valid_l, ev);
      if (done_m) done_cnt++;
      if (fetch_now && addrs.size() > 0) begin
        chk("rd_addr_m", rd_addr_m, addrs[0]);
        chk("rd_addr_l", rd_addr_l, addrs[0]);
        log_a.push_back(rd_addr_m);
        void'(addrs.pop_front());
      end
      if (ev && words.size() > 0) begin
        chk("tx_data_m", tx_data_m,
            byte_of(words[0], bidx, 1'b1));
        chk("tx_data_l", tx_data_l,
            byte_of(words[0], bidx, 1'b0));
        chk("tx_last_m", tx_last_m,
            (words.size() == 1 && bidx == 3));
        chk("tx_last_l", tx_last_l,
            (words.size() == 1 && bidx == 3));
      end
      fn = 0;
      dn = 0;
      if (active) begin
        if (ev && tx_ready && words.size() > 0) begin
          log_m.push_back(tx_data_m);
          log_l.push_back(tx_data_l);
          if (bidx == 3) begin
            void'(words.pop_front());
            bidx = 0;
            if (words.size() == 0) dn = 1;
            else fn = 1;
          end else begin
            bidx++;
          end
        end
        if (done_now) active = 0;
      end else if (start) begin
        nwords = ((int'(last_addr) - int'(first_addr)
                  + 32) % 32) + 1;
        for (int k = 0; k < nwords; k++) begin
          addrs.push_back(5'((int'(first_addr) + k) % 32));
          words.push_back(
            regs[(int'(first_addr) + k) % 32]);
        end
        bidx = 0;
        active = 1;
        fn = 1;
      end
      fetch_now = fn;
      done_now = dn;
    end
  end

  task automatic tick();
    @(posedge reg_clock);
    #1;
  endtask

  task automatic dump(logic [4:0] f, logic [4:0] l,
                      int mode, int abort_at);
    int n;
    n = 0;
    while (active && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", active, 0);
    log_m.delete();
    log_l.delete();
    log_a.delete();
    start = 1'b1;
    first_addr = f;
    last_addr = l;
    tx_ready = 1'b1;
    tick();
    start = 1'b0;
    first_addr = 5'($urandom);
    last_addr = 5'($urandom);
    n = 0;
    while (active && n < 3000) begin
      if (abort_at > 0 && log_m.size() >= abort_at)
        break;
      case (mode)
        1: tx_ready = ($urandom % 3) != 0;
        2: tx_ready = !(n >= 2 && n < 5);
        default: tx_ready = 1'b1;
      endcase
      if (mode == 1)
        start = done_now || ($urandom % 6 == 0);
      else
        start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    if (abort_at == 0) chk("dump_timeout", active, 0);
  endtask

  logic [7:0] e42 [8] = '{8'h11, 8'h22, 8'h33, 8'h44,
                          8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [4:0] e43 [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
  logic [7:0] e44 [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
  logic [7:0] e45 [8] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D,
                          8'h12, 8'h34, 8'h56, 8'h78};

  int dc;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    regs[3] = 32'h11223344;
    regs[4] = 32'hAABBCCDD;
    dc = done_cnt;
    dump(5'd3, 5'd4, 0, 0);
    chk("s42_len", log_m.size(), 8);
    for (int i = 0; i < 8 && i < log_m.size(); i++)
      chk("s42_byte", log_m[i], e42[i]);
    chk("s42_done", done_cnt - dc, 1);

    regs[0] = 32'h0;
    dump(5'd30, 5'd1, 0, 0);
    chk("s43_len", log_m.size(), 16);
    chk("s43_addrs", log_a.size(), 4);
    for (int i = 0; i < 4 && i < log_a.size(); i++)
      chk("s43_addr", log_a[i], e43[i]);
    if (log_m.size() > 9) chk("s43_r0b1", log_m[9], 0);

    regs[7] = 32'h01020304;
    dump(5'd7, 5'd7, 0, 0);
    chk("s44_len", log_l.size(), 4);
    for (int i = 0; i < 4 && i < log_l.size(); i++)
      chk("s44_byte", log_l[i], e44[i]);

    regs[10] = 32'hCAFEF00D;
    regs[11] = 32'h12345678;
    dump(5'd10, 5'd11, 2, 0);
    chk("s45_len", log_m.size(), 8);
    for (int i = 0; i < 8 && i < log_m.size(); i++)
      chk("s45_byte", log_m[i], e45[i]);

    dump(5'd5, 5'd9, 1, 0);
    chk("s46_busy_len", log_m.size(), 20);

    dump(5'd5, 5'd9, 0, 6);
    dc = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("s46_async_m", {rd_ena_m, rd_addr_m, tx_valid_m,
        tx_data_m, tx_last_m, busy_m, done_m}, 0);
    chk("s46_async_l", {rd_ena_l, rd_addr_l, tx_valid_l,
        tx_data_l, tx_last_l, busy_l, done_l}, 0);
    @(negedge reg_clock);
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("s46_no_done", done_cnt - dc, 0);
    dump(5'd5, 5'd9, 0, 0);
    chk("s46_redump_len", log_m.size(), 20);
    for (int i = 0; i < 20 && i < log_m.size(); i++)
      chk("s46_redump", log_m[i],
          byte_of(regs[5 + i / 4], i % 4, 1'b1));

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      dc = done_cnt;
      dump(5'($urandom), 5'($urandom), 1, 0);
      chk("rnd_done", done_cnt - dc, 1);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
